short_circuit_eval: RTL and testbench

Multi-cycle condition evaluator that sits directly upstream of the generated branch stage. It evaluates a chain of up to TERMS unsigned comparisons joined by a single logical operator (AND or OR), one term per clock, and stops as soon as the outcome is decided (short-circuit semantics). It then presents a boolean result and the selected branch value (TRUE_VAL / FALSE_VAL) for the branch stage to register into its output.

---
 rtl/short_circuit_eval_if.sv | 25 ++
 rtl/short_circuit_eval.sv | 83 ++++++++
 tb/tb_short_circuit_eval.sv | 135 +++++++++++++
 3 files changed

// File: rtl/short_circuit_eval_if.sv
// short_circuit_eval_if: request/result bundle between the condition evaluator and its requester
interface short_circuit_eval_if #(
  parameter int WIDTH = 32,
  parameter int TERMS = 4
);
  logic                     start;
  logic                     op_is_or;
  logic [2:0]               term_count;
  logic [3*TERMS-1:0]       cmp_code;
  logic [WIDTH*TERMS-1:0]   lhs;
  logic [WIDTH*TERMS-1:0]   rhs;
  logic                     busy;
  logic                     done;
  logic                     result;
  logic [WIDTH-1:0]         out_val;
  logic [2:0]               terms_evaluated;
  modport master (
    output start, op_is_or, term_count, cmp_code, lhs, rhs,
    input  busy, done, result, out_val, terms_evaluated
  );
  modport slave (
    input  start, op_is_or, term_count, cmp_code, lhs, rhs,
    output busy, done, result, out_val, terms_evaluated
  );
endinterface

// File: rtl/short_circuit_eval.sv
// short_circuit_eval: one-term-per-cycle AND/OR comparison chain with early exit
module short_circuit_eval #(
  parameter int               WIDTH     = 32,
  parameter int               TERMS     = 4,
  parameter logic [WIDTH-1:0] TRUE_VAL  = 32'd25,
  parameter logic [WIDTH-1:0] FALSE_VAL = 32'd15
) (
  input logic clk,
  input logic reset,
  short_circuit_eval_if.slave bus
);
  typedef enum logic {IDLE, EVAL} state_t;
  state_t                 state, state_n;
  logic [2:0]             idx, idx_n, cnt, code, te_n;
  logic                   op, t, fin, res_n;
  logic [3*TERMS-1:0]     codes;
  logic [WIDTH*TERMS-1:0] a, b;
  logic [WIDTH-1:0]       x, y;
  assign bus.busy = state == EVAL;
  always_comb begin
    code    = codes[3*idx +: 3];
    x       = a[WIDTH*idx +: WIDTH];
    y       = b[WIDTH*idx +: WIDTH];
    t       = code == 3'd0 ? x == y :
              code == 3'd1 ? x != y :
              code == 3'd2 ? x <  y :
              code == 3'd3 ? x <= y :
              code == 3'd4 ? x >  y :
              code == 3'd5 ? x >= y : 1'b0;
    state_n = state;
    idx_n   = idx;
    fin     = 1'b0;
    res_n   = t;
    te_n    = idx + 3'd1;
    if (state == IDLE) begin
      if (bus.start) begin
        state_n = EVAL;
        idx_n   = 3'd0;
      end
    end else if (cnt == 3'd0) begin
      // empty chain yields the operator identity
      fin   = 1'b1;
      res_n = ~op;
      te_n  = 3'd0;
    end else if ((op ? t : ~t) || idx == cnt - 3'd1) begin
      fin = 1'b1;
    end else begin
      idx_n = idx + 3'd1;
    end
    if (fin) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= 3'd0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.done            <= 1'b0;
      bus.result          <= 1'b0;
      bus.out_val         <= FALSE_VAL;
      bus.terms_evaluated <= 3'd0;
    end else begin
      bus.done <= fin;
      if (fin) begin
        bus.result          <= res_n;
        bus.out_val         <= res_n ? TRUE_VAL : FALSE_VAL;
        bus.terms_evaluated <= te_n;
      end
    end
    if (state == IDLE && bus.start) begin
      op    <= bus.op_is_or;
      cnt   <= bus.term_count > 3'(TERMS) ? 3'(TERMS) : bus.term_count;
      codes <= bus.cmp_code;
      a     <= bus.lhs;
      b     <= bus.rhs;
    end
  end
endmodule

// File: tb/tb_short_circuit_eval.sv
// tb_short_circuit_eval: table-driven checks plus back-to-back and mid-evaluation reset sequences
`timescale 1ns/1ps
module tb_short_circuit_eval;
  typedef struct {
    logic         op;
    logic [2:0]   cnt;
    logic [11:0]  codes;
    logic [127:0] l;
    logic [127:0] r;
    logic         res;
    logic [2:0]   te;
    int           lat;
  } vec_t;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  vec_t v[9];
  short_circuit_eval_if #(.WIDTH(32), .TERMS(4)) sc();
  short_circuit_eval #(.WIDTH(32), .TERMS(4), .TRUE_VAL(32'd25), .FALSE_VAL(32'd15)) dut (
    .clk(clk),
    .reset(reset),
    .bus(sc.slave)
  );
  always #5 clk = ~clk;
  function automatic logic [127:0] p4(logic [31:0] t0, logic [31:0] t1, logic [31:0] t2, logic [31:0] t3);
    return {t3, t2, t1, t0};
  endfunction
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic run(vec_t x, string n);
    int c;
    bit got;
    sc.op_is_or   = x.op;
    sc.term_count = x.cnt;
    sc.cmp_code   = x.codes;
    sc.lhs        = x.l;
    sc.rhs        = x.r;
    sc.start      = 1'b1;
    @(posedge clk); #1;
    sc.start = 1'b0;
    chk({n, " busy"}, 32'(sc.busy), 32'd1);
    c   = 0;
    got = 0;
    while (!got && c < 12) begin
      @(posedge clk); #1;
      c++;
      got = sc.done;
    end
    chk({n, " latency"}, c, x.lat);
    chk({n, " result"}, 32'(sc.result), 32'(x.res));
    chk({n, " out_val"}, sc.out_val, x.res ? 32'd25 : 32'd15);
    chk({n, " terms"}, 32'(sc.terms_evaluated), 32'(x.te));
  endtask
  initial begin
    v[0] = '{1'b0, 3'd1, {3'd0, 3'd0, 3'd0, 3'd0}, p4(291, 0, 0, 0), p4(4, 0, 0, 0), 1'b0, 3'd1, 1};
    v[1] = '{1'b0, 3'd4, {3'd0, 3'd0, 3'd0, 3'd0}, p4(4, 7, 9, 11), p4(4, 7, 9, 11), 1'b1, 3'd4, 4};
    v[2] = '{1'b0, 3'd4, {3'd7, 3'd7, 3'd4, 3'd0}, p4(5, 3, 0, 0), p4(5, 4, 0, 0), 1'b0, 3'd2, 2};
    v[3] = '{1'b1, 3'd3, {3'd0, 3'd0, 3'd0, 3'd2}, p4(5, 1, 1, 0), p4(9, 1, 1, 0), 1'b1, 3'd1, 1};
    v[4] = '{1'b1, 3'd0, {3'd0, 3'd0, 3'd0, 3'd0}, p4(1, 1, 1, 1), p4(1, 1, 1, 1), 1'b0, 3'd0, 1};
    v[5] = '{1'b0, 3'd0, {3'd7, 3'd7, 3'd7, 3'd7}, p4(0, 0, 0, 0), p4(1, 1, 1, 1), 1'b1, 3'd0, 1};
    v[6] = '{1'b1, 3'd3, {3'd0, 3'd6, 3'd1, 3'd2}, p4(9, 4, 0, 0), p4(5, 4, 0, 0), 1'b0, 3'd3, 3};
    v[7] = '{1'b0, 3'd7, {3'd1, 3'd2, 3'd5, 3'd3}, p4(3, 0, 1, 1), p4(3, 0, 32'hFFFF_FFFF, 0), 1'b1, 3'd4, 4};
    v[8] = '{1'b1, 3'd4, {3'd4, 3'd7, 3'd7, 3'd7}, p4(0, 0, 0, 32'h8000_0000), p4(0, 0, 0, 1), 1'b1, 3'd4, 4};
    reset         = 1'b1;
    sc.start      = 1'b0;
    sc.op_is_or   = 1'b0;
    sc.term_count = 3'd0;
    sc.cmp_code   = '0;
    sc.lhs        = '0;
    sc.rhs        = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset busy", 32'(sc.busy), 32'd0);
    chk("reset done", 32'(sc.done), 32'd0);
    chk("reset result", 32'(sc.result), 32'd0);
    chk("reset out_val", sc.out_val, 32'd15);
    chk("reset terms", 32'(sc.terms_evaluated), 32'd0);
    for (int i = 0; i < 9; i++) run(v[i], $sformatf("vec%0d", i));
    // start held high: capture and finish alternate, inputs changed while busy are ignored
    @(posedge clk); #1;
    sc.op_is_or   = 1'b0;
    sc.term_count = 3'd2;
    sc.cmp_code   = '0;
    sc.lhs        = p4(1, 5, 0, 0);
    sc.rhs        = p4(2, 5, 0, 0);
    sc.start      = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("held busy c%0d", k), 32'(sc.busy), 32'(k % 2 == 0));
      chk($sformatf("held done c%0d", k), 32'(sc.done), 32'(k % 2 == 1));
      if (k % 2 == 1) begin
        chk($sformatf("held result c%0d", k), 32'(sc.result), 32'd0);
        chk($sformatf("held terms c%0d", k), 32'(sc.terms_evaluated), 32'd1);
        sc.lhs = p4(1, 5, 0, 0);
      end else begin
        sc.lhs = p4(2, 5, 0, 0);
      end
    end
    sc.start = 1'b0;
    @(posedge clk); #1;
    run(v[1], "pre_abort");
    // reset lands on E2 of a 4-term all-true AND
    sc.op_is_or   = v[1].op;
    sc.term_count = v[1].cnt;
    sc.cmp_code   = v[1].codes;
    sc.lhs        = v[1].l;
    sc.rhs        = v[1].r;
    sc.start      = 1'b1;
    @(posedge clk); #1;
    sc.start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort busy", 32'(sc.busy), 32'd0);
    chk("abort done", 32'(sc.done), 32'd0);
    chk("abort result", 32'(sc.result), 32'd0);
    chk("abort out_val", sc.out_val, 32'd15);
    chk("abort terms", 32'(sc.terms_evaluated), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("abort no done c%0d", k), 32'(sc.done), 32'd0);
    end
    run(v[1], "post_abort");
    run(v[2], "post_abort2");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
